// File: rtl/msp_port_bank.sv
// msp_port_bank: parametrised bidirectional I/O port bank on the 6809 data bus.
// Each port has a DDR, a two-flop input synchroniser, per-bit edge-detect
// interrupt flags with a mask, and all flags fold into one registered IRQ_N.
module msp_port_bank #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic                       CLKIN,
    input  logic                       RESET_N,
    input  logic                       ENA,
    input  logic                       SEL,
    input  logic [ADDR_W-1:0]          ADDR,
    input  logic                       RW_N,
    input  logic [7:0]                 DATA_I,
    output logic [7:0]                 DATA_O,
    input  logic [NUM_PORTS*WIDTH-1:0] PORT_IN,
    output logic [NUM_PORTS*WIDTH-1:0] PORT_OUT,
    output logic [NUM_PORTS*WIDTH-1:0] PORT_OE,
    output logic                       IRQ_N
);

    localparam int unsigned PW    = NUM_PORTS * WIDTH;
    localparam int unsigned IDX_W = ADDR_W - 3;

    localparam logic [2:0] OFF_DATA  = 3'd0;
    localparam logic [2:0] OFF_DDR   = 3'd1;
    localparam logic [2:0] OFF_EDGE  = 3'd2;
    localparam logic [2:0] OFF_IMASK = 3'd3;
    localparam logic [2:0] OFF_IFLAG = 3'd4;

    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        PRIME2 = 2'd2,
        DONE   = 2'd3
    } prime_t;

    prime_t prime_q;

    logic [PW-1:0] out_q;
    logic [PW-1:0] ddr_q;
    logic [PW-1:0] edg_q;
    logic [PW-1:0] mask_q;
    logic [PW-1:0] flag_q;
    logic [PW-1:0] s1_q;
    logic [PW-1:0] s2_q;
    logic [PW-1:0] prev_q;

    logic [IDX_W-1:0]     port_idx;
    logic [2:0]           reg_off;
    logic                 wr_stb;
    logic [WIDTH-1:0]     wdata;
    logic [NUM_PORTS-1:0] port_hit;
    logic [PW-1:0]        edge_hit;
    logic [PW-1:0]        flag_set;
    logic [PW-1:0]        flag_clr;
    logic [WIDTH-1:0]     rd_field;

    assign port_idx = ADDR[ADDR_W-1:3];
    assign reg_off  = ADDR[2:0];
    assign wr_stb   = SEL & ENA & ~RW_N;
    assign wdata    = DATA_I[WIDTH-1:0];

    // Only DDR=1 bits drive the pins; the latch keeps its full value
    assign PORT_OUT = out_q & ddr_q;
    assign PORT_OE  = ddr_q;

    // Port select decode; indices at or beyond NUM_PORTS match nothing
    always_comb begin
        port_hit = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_hit[p] = (port_idx == IDX_W'(p));
        end
    end

    // Edge qualification: direction per EDGE, inputs only, and only once primed
    assign edge_hit = ((s2_q & ~prev_q & edg_q) | (~s2_q & prev_q & ~edg_q)) & ~ddr_q;
    assign flag_set = (prime_q == DONE) ? edge_hit : '0;

    // Write-1-to-clear mask for the addressed port's IFLAG
    always_comb begin
        flag_clr = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (wr_stb && port_hit[p] && (reg_off == OFF_IFLAG)) begin
                flag_clr[p*WIDTH +: WIDTH] = wdata;
            end
        end
    end

    // CPU-visible registers; a flag set beats a same-cycle clear
    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            out_q  <= '0;
            ddr_q  <= '0;
            edg_q  <= '0;
            mask_q <= '0;
            flag_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (wr_stb && port_hit[p]) begin
                    case (reg_off)
                        OFF_DATA:  out_q[p*WIDTH +: WIDTH]  <= wdata;
                        OFF_DDR:   ddr_q[p*WIDTH +: WIDTH]  <= wdata;
                        OFF_EDGE:  edg_q[p*WIDTH +: WIDTH]  <= wdata;
                        OFF_IMASK: mask_q[p*WIDTH +: WIDTH] <= wdata;
                        default:   ;
                    endcase
                end
            end
            flag_q <= (flag_q & ~flag_clr) | flag_set;
        end
    end

    // Input synchroniser plus one history stage for edge detection
    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= PORT_IN;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Prime sequencer: hold off edge detection while the synchroniser fills
    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            prime_q <= PRIME0;
        end else begin
            case (prime_q)
                PRIME0: prime_q <= PRIME1;
                PRIME1: prime_q <= PRIME2;
                PRIME2: prime_q <= DONE;
                DONE:   prime_q <= DONE;
            endcase
        end
    end

    // Registered active-low interrupt from all enabled flags
    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            IRQ_N <= 1'b1;
        end else begin
            IRQ_N <= ~|(flag_q & mask_q);
        end
    end

    // Read mux; unmapped offsets and ports read zero
    always_comb begin
        rd_field = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (port_hit[p]) begin
                case (reg_off)
                    OFF_DATA:  rd_field = (out_q[p*WIDTH +: WIDTH] & ddr_q[p*WIDTH +: WIDTH])
                                        | (s2_q[p*WIDTH +: WIDTH] & ~ddr_q[p*WIDTH +: WIDTH]);
                    OFF_DDR:   rd_field = ddr_q[p*WIDTH +: WIDTH];
                    OFF_EDGE:  rd_field = edg_q[p*WIDTH +: WIDTH];
                    OFF_IMASK: rd_field = mask_q[p*WIDTH +: WIDTH];
                    OFF_IFLAG: rd_field = flag_q[p*WIDTH +: WIDTH];
                    default:   rd_field = '0;
                endcase
            end
        end
        DATA_O = SEL ? 8'(rd_field) : 8'h00;
    end

endmodule

// File: tb/tb_msp_port_bank.sv
// Bench for msp_port_bank: directed scenarios plus randomized traffic checked
// against a pin-history reference model.
module tb_msp_port_bank;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          sel;
    logic          sel_s;
    logic [AW-1:0] addr;
    logic          rw_n;
    logic [7:0]    data_i;
    logic [7:0]    data_o;
    logic [7:0]    data_o_s;
    logic [31:0]   port_in;
    logic [31:0]   port_out;
    logic [31:0]   port_oe;
    logic          irq_n;
    logic [14:0]   port_in_s;
    logic [14:0]   port_out_s;
    logic [14:0]   port_oe_s;
    logic          irq_n_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    msp_port_bank #(.NUM_PORTS(NP), .WIDTH(W), .ADDR_W(AW)) dut (
        .CLKIN(clk), .RESET_N(rst_n), .ENA(ena), .SEL(sel), .ADDR(addr),
        .RW_N(rw_n), .DATA_I(data_i), .DATA_O(data_o), .PORT_IN(port_in),
        .PORT_OUT(port_out), .PORT_OE(port_oe), .IRQ_N(irq_n)
    );

    msp_port_bank #(.NUM_PORTS(3), .WIDTH(5), .ADDR_W(AW)) dut_s (
        .CLKIN(clk), .RESET_N(rst_n), .ENA(ena), .SEL(sel_s), .ADDR(addr),
        .RW_N(rw_n), .DATA_I(data_i), .DATA_O(data_o_s), .PORT_IN(port_in_s),
        .PORT_OUT(port_out_s), .PORT_OE(port_oe_s), .IRQ_N(irq_n_s)
    );

    // Reference model: register contents plus the last three sampled pin words
    logic [7:0]  m_out [NP];
    logic [7:0]  m_ddr [NP];
    logic [7:0]  m_edg [NP];
    logic [7:0]  m_msk [NP];
    logic [7:0]  m_flg [NP];
    logic        m_irq_n;
    logic [31:0] smp [3];
    int          cnt;

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            m_out[p] = '0; m_ddr[p] = '0; m_edg[p] = '0; m_msk[p] = '0; m_flg[p] = '0;
        end
        m_irq_n = 1'b1;
        for (int i = 0; i < 3; i++) smp[i] = '0;
        cnt = 0;
    endfunction

    // Advance the model across one rising edge using the currently driven inputs
    function automatic void model_step();
        logic       wr;
        int         wp;
        logic [2:0] off;
        logic       any;
        logic [7:0] h2, h3, st, c;
        wr  = sel && ena && !rw_n;
        wp  = int'(addr[5:3]);
        off = addr[2:0];
        any = 1'b0;
        for (int p = 0; p < NP; p++) if ((m_flg[p] & m_msk[p]) != 8'h00) any = 1'b1;
        for (int p = 0; p < NP; p++) begin
            h2 = smp[1][p*8 +: 8];
            h3 = smp[2][p*8 +: 8];
            st = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (cnt >= 3 && h2[b] != h3[b] && !m_ddr[p][b] && h2[b] == m_edg[p][b])
                    st[b] = 1'b1;
            end
            c = (wr && wp == p && off == 3'd4) ? data_i : 8'h00;
            m_flg[p] = (m_flg[p] & ~c) | st;
            if (wr && wp == p) begin
                case (off)
                    3'd0: m_out[p] = data_i;
                    3'd1: m_ddr[p] = data_i;
                    3'd2: m_edg[p] = data_i;
                    3'd3: m_msk[p] = data_i;
                    default: ;
                endcase
            end
        end
        m_irq_n = !any;
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = port_in;
        if (cnt < 3) cnt++;
    endfunction

    function automatic logic [7:0] exp_read(input logic [5:0] a);
        int p;
        p = int'(a[5:3]);
        if (p >= NP) return 8'h00;
        case (a[2:0])
            3'd0: return (m_out[p] & m_ddr[p]) | (smp[1][p*8 +: 8] & ~m_ddr[p]);
            3'd1: return m_ddr[p];
            3'd2: return m_edg[p];
            3'd3: return m_msk[p];
            3'd4: return m_flg[p];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] exp_out();
        logic [31:0] v;
        for (int p = 0; p < NP; p++) v[p*8 +: 8] = m_out[p] & m_ddr[p];
        return v;
    endfunction

    function automatic logic [31:0] exp_oe();
        logic [31:0] v;
        for (int p = 0; p < NP; p++) v[p*8 +: 8] = m_ddr[p];
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        sel = 1'b1; rw_n = 1'b0; addr = a; data_i = d;
        tick();
        sel = 1'b0; rw_n = 1'b1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] v);
        sel = 1'b1; rw_n = 1'b1; addr = a;
        #1;
        v = data_o;
        sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0; ena = 1'b1; sel = 1'b0; sel_s = 1'b0; rw_n = 1'b1;
        addr = '0; data_i = '0; port_in = '1; port_in_s = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (port_out !== 32'h0 || port_oe !== 32'h0 || irq_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: out=%h oe=%h irq_n=%b, need 0/0/1", port_out, port_oe, irq_n);
        end
        n_checks++;
        if (data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sel0_read: got %h need 00", data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        for (int p = 0; p < NP; p++) begin
            rd(6'(p*8 + 4), v);
            n_checks++;
            if (v !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_iflag_p%0d: got %h need 00", p, v);
            end
        end
        tick();
        for (int p = 0; p < NP; p++) begin
            rd(6'(p*8), v);
            n_checks++;
            if (v !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_data_p%0d: got %h need ff", p, v);
            end
        end
        n_checks++;
        if (irq_n !== 1'b1 || port_oe !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_primed: irq_n=%b oe=%h, need 1/0", irq_n, port_oe);
        end
    endtask

    task automatic test_port_io();
        logic [7:0] v;
        port_in = 32'h0000_3000;
        wr(6'd9, 8'h0F);
        wr(6'd8, 8'hA5);
        n_checks++;
        if (port_oe[15:8] !== 8'h0F || port_out[15:8] !== 8'h05) begin
            n_fail++;
            $display("FAIL port1_drive: oe=%h out=%h, need 0f/05", port_oe[15:8], port_out[15:8]);
        end
        rd(6'd8, v);
        n_checks++;
        if (v !== 8'h35) begin
            n_fail++;
            $display("FAIL port1_data_read: got %h need 35", v);
        end
        rd(6'd13, v);
        n_checks++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL port1_off5_read: got %h need 00", v);
        end
        addr = 6'd8; rw_n = 1'b1; sel = 1'b0; #1;
        n_checks++;
        if (data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL sel0_read: got %h need 00", data_o);
        end
        wr(6'd40, 8'hFF);
        wr(6'd41, 8'hFF);
        n_checks++;
        if (port_out !== exp_out() || port_oe !== exp_oe()) begin
            n_fail++;
            $display("FAIL bad_port_write: out=%h oe=%h, need %h/%h", port_out, port_oe, exp_out(), exp_oe());
        end
    endtask

    task automatic test_edge_irq();
        logic [7:0] v;
        idle(4);
        wr(6'd20, 8'hFF);
        wr(6'd18, 8'h01);
        wr(6'd19, 8'h01);
        port_in[16] = 1'b1;
        tick();
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL edge_flag_N: got %h need 00", v); end
        tick();
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL edge_flag_N1: got %h need 00", v); end
        tick();
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h01 || irq_n !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_flag_N2: flag=%h irq_n=%b, need 01/1", v, irq_n);
        end
        tick();
        n_checks++;
        if (irq_n !== 1'b0) begin n_fail++; $display("FAIL edge_irq_N3: got %b need 0", irq_n); end
        port_in[16] = 1'b0;
        idle(4);
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h01 || irq_n !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_sticky: flag=%h irq_n=%b, need 01/0", v, irq_n);
        end
    endtask

    task automatic test_set_clear_collision();
        logic [7:0] v;
        port_in[16] = 1'b1;
        tick();
        tick();
        wr(6'd20, 8'h01);
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h01 || irq_n !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_set_wins: flag=%h irq_n=%b, need 01/0", v, irq_n);
        end
        wr(6'd20, 8'h01);
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h00 || irq_n !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flag: flag=%h irq_n=%b, need 00/0", v, irq_n);
        end
        tick();
        n_checks++;
        if (irq_n !== 1'b1) begin n_fail++; $display("FAIL clear_irq: got %b need 1", irq_n); end
    endtask

    task automatic test_mask();
        logic [7:0] v;
        wr(6'd19, 8'h00);
        port_in[16] = 1'b0;
        idle(4);
        port_in[16] = 1'b1;
        idle(4);
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h01 || irq_n !== 1'b1) begin
            n_fail++;
            $display("FAIL masked_flag: flag=%h irq_n=%b, need 01/1", v, irq_n);
        end
        wr(6'd19, 8'h01);
        n_checks++;
        if (irq_n !== 1'b1) begin n_fail++; $display("FAIL mask_write_edge: got %b need 1", irq_n); end
        tick();
        n_checks++;
        if (irq_n !== 1'b0) begin n_fail++; $display("FAIL mask_irq: got %b need 0", irq_n); end
        wr(6'd20, 8'h01);
    endtask

    task automatic test_ena_gate();
        logic [7:0] v;
        tick();
        ena = 1'b0;
        port_in[16] = 1'b0;
        wr(6'd17, 8'hFF);
        idle(3);
        port_in[16] = 1'b1;
        idle(4);
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h01 || port_oe[23:16] !== 8'h00) begin
            n_fail++;
            $display("FAIL ena_gate: flag=%h oe=%h, need 01/00", v, port_oe[23:16]);
        end
        wr(6'd20, 8'h01);
        rd(6'd20, v);
        n_checks++;
        if (v !== 8'h01 || irq_n !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_noclear: flag=%h irq_n=%b, need 01/0", v, irq_n);
        end
        ena = 1'b1;
        wr(6'd20, 8'hFF);
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [5:0] ra;
        for (int i = 0; i < 300; i++) begin
            port_in = port_in ^ ($urandom & $urandom & $urandom);
            ena     = ($urandom_range(0, 3) != 0);
            sel     = $urandom_range(0, 1);
            rw_n    = ($urandom_range(0, 2) == 0);
            addr    = 6'($urandom);
            data_i  = 8'($urandom);
            tick();
            sel = 1'b0; rw_n = 1'b1;
            n_checks++;
            if (port_out !== exp_out() || port_oe !== exp_oe()) begin
                n_fail++;
                $display("FAIL rand_pins[%0d]: out=%h oe=%h, need %h/%h", i, port_out, port_oe, exp_out(), exp_oe());
            end
            n_checks++;
            if (irq_n !== m_irq_n) begin
                n_fail++;
                $display("FAIL rand_irq[%0d]: got %b need %b", i, irq_n, m_irq_n);
            end
            ra = 6'($urandom);
            rd(ra, v);
            n_checks++;
            if (v !== exp_read(ra)) begin
                n_fail++;
                $display("FAIL rand_read[%0d] addr %0d: got %h need %h", i, ra, v, exp_read(ra));
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic [7:0] v;
        wr(6'd1, 8'hF0);
        wr(6'd0, 8'hFF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (port_out !== 32'h0 || port_oe !== 32'h0 || irq_n !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: out=%h oe=%h irq_n=%b, need 0/0/1", port_out, port_oe, irq_n);
        end
        port_in = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        for (int p = 0; p < NP; p++) begin
            rd(6'(p*8 + 4), v);
            n_checks++;
            if (v !== 8'h00) begin
                n_fail++;
                $display("FAIL rereset_iflag_p%0d: got %h need 00", p, v);
            end
        end
    endtask

    task automatic test_small();
        logic [7:0] v;
        sel_s = 1'b1; rw_n = 1'b0; addr = 6'd24; data_i = 8'hFF; tick();
        addr = 6'd25; tick();
        rw_n = 1'b1; addr = 6'd24; #1;
        n_checks++;
        if (port_out_s !== 15'h0 || port_oe_s !== 15'h0 || data_o_s !== 8'h00) begin
            n_fail++;
            $display("FAIL small_bad_port: out=%h oe=%h rd=%h, need 0/0/00", port_out_s, port_oe_s, data_o_s);
        end
        rw_n = 1'b0; addr = 6'd1; data_i = 8'hFF; tick();
        rw_n = 1'b1; #1;
        v = data_o_s;
        n_checks++;
        if (v !== 8'h1F || port_oe_s !== 15'h001F) begin
            n_fail++;
            $display("FAIL small_ddr_width: rd=%h oe=%h, need 1f/001f", v, port_oe_s);
        end
        sel_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_port_io();
        test_edge_irq();
        test_set_clear_collision();
        test_mask();
        test_ena_gate();
        test_random();
        test_mid_reset();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msp_port_bank.md
# msp_port_bank

Parametrised I/O port bank for the Music/Speech SOC, replacing the fixed, output-only PORT_A..PORT_D wiring. It provides NUM_PORTS bidirectional ports of WIDTH bits each on the 6809 data bus. Each port has a data direction register, a two-flop input synchroniser, and per-bit edge-detect interrupt flags with a mask. The flags combine into one registered active-low interrupt that feeds the CPU IRQ or FIRQ input.

## Interface
- NUM_PORTS, 4: number of ports, 1..8
- WIDTH, 8: bits per port, 1..8; register bits [7:WIDTH] read 0 and ignore writes
- ADDR_W, 6: register address width; must be ≥ clog2(NUM_PORTS)+3

- CLKIN  in  1  system clock; all state is on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ENA  in  1  CPU cycle enable; register writes occur only when high
- SEL  in  1  block select, decoded externally from ADDRESS
- ADDR  in  ADDR_W  register address: [ADDR_W-1:3] selects the port, [2:0] selects the register
- RW_N  in  1  1 = read, 0 = write
- DATA_I  in  8  CPU write data
- DATA_O  out  8  read data (combinational)
- PORT_IN  in  NUM_PORTS*WIDTH  pin inputs, asynchronous to CLKIN; port p occupies bits [p*WIDTH +: WIDTH]
- PORT_OUT  out  NUM_PORTS*WIDTH  output latches
- PORT_OE  out  NUM_PORTS*WIDTH  per-bit output enable, equal to the DDR
- IRQ_N  out  1  registered active-low interrupt

## Operation
- Register offsets within a port:
  - 0 DATA: write loads the output latch. Read returns the latch for DDR=1 bits and the synchronised pin for DDR=0 bits.
  - 1 DDR: 1 = output.
  - 2 EDGE: 1 = rising edge, 0 = falling edge.
  - 3 IMASK: 1 = bit enabled onto IRQ_N.
  - 4 IFLAG: read returns the flags; writing 1 clears a bit, writing 0 has no effect.
  - 5..7: read 0, writes ignored.
- A port index ≥ NUM_PORTS reads 0 and ignores writes.
- Write strobe = SEL & ENA & ~RW_N. Reads have no side effects.
- DATA_O = 0 when SEL=0.
- Synchroniser per input bit: s1 <= pin, s2 <= s1, prev <= s2.
- An edge is detected on a bit when s2 != prev, the direction matches EDGE, the bit's DDR = 0, and the prime state is DONE.
  - Rising edge: s2=1, prev=0.
  - Falling edge: s2=0, prev=1.
- An edge sets the corresponding IFLAG bit. If a set and a write-1-clear hit the same bit in the same cycle, the set wins.
- Flags are sticky. They are unaffected by later DDR, EDGE or IMASK changes, and a masked flag still sets.
- IRQ_N <= ~|(IFLAG & IMASK) over all ports, registered.
- Prime state machine, 2-bit counter:
  - States: PRIME0 → PRIME1 → PRIME2 → DONE, one step per clock after reset release.
  - DONE holds until the next reset.
  - While not DONE, edge detection is suppressed so that synchroniser fill after reset cannot raise spurious flags.
- Changing EDGE or DDR does not create an edge by itself; only pin transitions set flags.

## Timing
- Reset state (asynchronous, while RESET_N=0):
  - Output latches, DDR, EDGE, IMASK, IFLAG, s1, s2 and prev are all 0.
  - Prime state is PRIME0.
  - PORT_OUT=0, PORT_OE=0, IRQ_N=1.
  - DATA_O follows its combinational rule.
- A register write is visible on PORT_OUT, PORT_OE and readback on the clock edge that samples the strobe, with zero added latency.
- Pin to flag:
  - A pin change setting up before edge N reaches s1 at N, s2 at N+1, and sets the flag at N+2.
  - IRQ_N falls at N+3 if the bit is masked in.
- DATA readback of an input bit reflects s2, so it lags the pin by 2 clocks.
- Clear to IRQ_N: an IFLAG write-1 at edge M clears the flag at M, and IRQ_N rises at M+1 unless another enabled flag is set.
- IMASK write at edge M changes IRQ_N at M+1.
- Reset asserted mid-operation: all state returns to reset values immediately, with no waiting for a clock.
- After RESET_N rises:
  - The first edge moves the prime state to PRIME1.
  - Flags can first set on the 4th rising edge, in state DONE.
- ENA=0 with a write strobe otherwise valid: no register changes. The synchroniser, flags and IRQ_N continue to run.

## Test plan
- Reset with PORT_IN all 1s, then release for 10 clocks -> IFLAG reads 0x00 on every port, IRQ_N=1, PORT_OE=0, DATA reads 0xFF (input bits).
- Port 1: write DDR=0x0F and DATA=0xA5, with PORT_IN port-1 field 0x30 -> PORT_OE field 0x0F, PORT_OUT field 0x05 (only the DDR=1 bits 0x0F are driven; the latch holds 0xA5), DATA reads 0x35 after 2 clocks.
- Port 2: EDGE=0x01, IMASK=0x01; pin bit0 0→1 before edge N -> IFLAG=0x01 at N+2, IRQ_N=0 at N+3. A later 1→0 transition leaves the flag set.
- Write IFLAG=0x01 in the same cycle a new rising edge on bit0 reaches s2 -> flag stays 1 and IRQ_N stays 0. Writing IFLAG=0x01 one cycle later clears it, and IRQ_N=1 on the following edge.
- IMASK=0 with an edge -> flag sets and IRQ_N stays 1. Then write IMASK=0x01 -> IRQ_N=0 on the next edge.
- NUM_PORTS=3, WIDTH=5: write port 3 DATA -> no output change, reads 0. Port 0 writing 0xFF to DDR reads back 0x1F.
